// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bus between the DECA_4 timing sequencer, RAM data-out and decode.
// master = sequencer side, slave = environment (decode / RAM / debug) side.
interface cpu_sequencer_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
);
  logic                   start;
  logic                   EXTRA;
  logic [WORD_W-1:0]      mem_q;
  logic                   step_mode;
  logic                   step;
  logic                   FETCH;
  logic                   EXEC1;
  logic                   EXEC2;
  logic [OP_W-1:0]        IR;
  logic [WORD_W-OP_W-1:0] N;
  logic                   HALTED;
  logic                   busy;
  logic [CNT_W-1:0]       cycle_count;
  logic [CNT_W-1:0]       instr_count;

  modport master (
    input  start, EXTRA, mem_q, step_mode, step,
    output FETCH, EXEC1, EXEC2, IR, N, HALTED, busy, cycle_count, instr_count
  );

  modport slave (
    output start, EXTRA, mem_q, step_mode, step,
    input  FETCH, EXEC1, EXEC2, IR, N, HALTED, busy, cycle_count, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: DECA_4 timing-state generator (FETCH/EXEC1/EXEC2 strobes),
// instruction register, STP halt and debug cycle/instruction counters.
// Optional feature macro: CPU_SEQ_SINGLE_STEP_EN (adds PAUSE state, step_mode/step).
module cpu_sequencer #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic clk,
  input  logic reset,
  cpu_sequencer_if.master bus
);

  localparam int unsigned N_W = WORD_W - OP_W;
  localparam logic [OP_W-1:0] STP_OP = OP_W'(4'h7);

`ifdef CPU_SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4
  } state_t;
`endif

  state_t            state, next_state;
  state_t            done_target;
  logic              instr_done;

  logic              fetch_q, exec1_q, exec2_q, halted_q, busy_q;
  logic [OP_W-1:0]   ir_q;
  logic [N_W-1:0]    n_q;
  logic [CNT_W-1:0]  cycle_cnt_q, instr_cnt_q;

`ifndef CPU_SEQ_SINGLE_STEP_EN
  // Single-step inputs have no function without the step feature.
  logic unused_step_inputs;
  assign unused_step_inputs = ^{bus.step_mode, bus.step};
`endif

  // Where an instruction goes when it completes: next FETCH, or PAUSE when stepping.
  always_comb begin
    done_target = S_FETCH;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    if (bus.step_mode) done_target = S_PAUSE;
`endif
  end

  // Next-state logic; instr_done flags a completing EXEC1/EXEC2 transition.
  always_comb begin
    next_state = state;
    instr_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) next_state = S_FETCH;
      end
      S_FETCH: begin
        next_state = S_EXEC1;
      end
      S_EXEC1: begin
        if (ir_q == STP_OP) begin
          next_state = S_HALT;
        end else if (bus.EXTRA) begin
          next_state = S_EXEC2;
        end else begin
          next_state = done_target;
          instr_done = 1'b1;
        end
      end
      S_EXEC2: begin
        next_state = done_target;
        instr_done = 1'b1;
      end
      S_HALT: begin
        next_state = S_HALT;
      end
`ifdef CPU_SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (bus.step || !bus.step_mode) next_state = S_FETCH;
      end
`endif
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Registered one-hot strobes and status, loaded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_q  <= 1'b0;
      exec1_q  <= 1'b0;
      exec2_q  <= 1'b0;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      fetch_q  <= (next_state == S_FETCH);
      exec1_q  <= (next_state == S_EXEC1);
      exec2_q  <= (next_state == S_EXEC2);
      halted_q <= (next_state == S_HALT);
      busy_q   <= (next_state == S_FETCH) || (next_state == S_EXEC1) ||
                  (next_state == S_EXEC2);
    end
  end

  // Instruction register: captures RAM data on the FETCH -> EXEC1 edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
      n_q  <= '0;
    end else if (state == S_FETCH) begin
      ir_q <= bus.mem_q[WORD_W-1 -: OP_W];
      n_q  <= bus.mem_q[N_W-1:0];
    end
  end

  // Debug counters: busy cycles and completed instructions, both wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (busy_q)     cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (instr_done) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign bus.FETCH       = fetch_q;
  assign bus.EXEC1       = exec1_q;
  assign bus.EXEC2       = exec2_q;
  assign bus.HALTED      = halted_q;
  assign bus.busy        = busy_q;
  assign bus.IR          = ir_q;
  assign bus.N           = n_q;
  assign bus.cycle_count = cycle_cnt_q;
  assign bus.instr_count = instr_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed + randomized bench for cpu_sequencer with an
// instruction-level reference model (cycles per instruction, completed count).
// Counters use an 8-bit width so the wrap boundary is reachable quickly.
module tb_cpu_sequencer;

  localparam int unsigned TB_WORD_W = 16;
  localparam int unsigned TB_OP_W   = 4;
  localparam int unsigned TB_CNT_W  = 8;
  localparam int          CNT_MOD   = 1 << TB_CNT_W;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  // Reference model state: total busy cycles and completed instructions.
  int m_cyc = 0;
  int m_ins = 0;

  cpu_sequencer_if #(.WORD_W(TB_WORD_W), .OP_W(TB_OP_W), .CNT_W(TB_CNT_W)) bus ();

  cpu_sequencer #(.WORD_W(TB_WORD_W), .OP_W(TB_OP_W), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] wrapc(input int v);
    return 32'(v % CNT_MOD);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic [2:0] exp);
    chk(tag, 32'({bus.FETCH, bus.EXEC1, bus.EXEC2}), 32'(exp));
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_cyc"}, 32'(bus.cycle_count), wrapc(m_cyc));
    chk({tag, "_ins"}, 32'(bus.instr_count), wrapc(m_ins));
  endtask

  // One instruction from its FETCH cycle; the next posedge must enter FETCH.
  task automatic run_instr(input logic [15:0] word, input logic extra);
    logic stp;
    stp = (word[15:12] == 4'h7);
    @(negedge clk);
    chk_strobes("fetch", 3'b100);
    chk("fetch_busy", 32'(bus.busy), 32'd1);
    chk_counters("fetch");
    bus.mem_q = word;
    bus.EXTRA = 1'($urandom);
    bus.start = 1'($urandom);
    bus.step  = 1'b0;
    @(negedge clk);
    chk_strobes("exec1", 3'b010);
    chk("exec1_ir", 32'(bus.IR), 32'(word[15:12]));
    chk("exec1_n", 32'(bus.N), 32'(word[11:0]));
    chk("exec1_cyc", 32'(bus.cycle_count), wrapc(m_cyc + 1));
    bus.EXTRA = extra;
    bus.mem_q = 16'($urandom);
    if (stp) begin
      m_cyc += 2;
      @(negedge clk);
      chk_strobes("stp_strobes", 3'b000);
      chk("stp_halted", 32'(bus.HALTED), 32'd1);
      chk("stp_busy", 32'(bus.busy), 32'd0);
      chk_counters("stp");
    end else if (extra) begin
      @(negedge clk);
      chk_strobes("exec2", 3'b001);
      chk("exec2_ir", 32'(bus.IR), 32'(word[15:12]));
      bus.EXTRA = 1'($urandom);
      m_cyc += 3;
      m_ins += 1;
    end else begin
      m_cyc += 2;
      m_ins += 1;
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'h7) w[15:12] = 4'h3;
    return w;
  endfunction

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.EXTRA     = 1'b0;
    bus.mem_q     = '0;
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_strobes("rst_strobes", 3'b000);
    chk("rst_halted", 32'(bus.HALTED), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ir", 32'(bus.IR), 32'd0);
    chk("rst_n", 32'(bus.N), 32'd0);
    chk_counters("rst");
    reset = 1'b0;

    // IDLE holds without start
    repeat (3) begin
      @(negedge clk);
      chk_strobes("idle_strobes", 3'b000);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end

    // Start, then the directed examples, then random instructions
    bus.start = 1'b1;
    run_instr(16'h2005, 1'b1);
    run_instr(16'h8003, 1'b0);
    run_instr(16'h0FFF, 1'b0);
    run_instr(16'hF000, 1'b1);
    for (int i = 0; i < 60; i++) run_instr(rand_word(), 1'($urandom));

    // Drive instr_count to all-ones, then one more completion wraps it
    for (int i = 0; i < 2 * CNT_MOD && wrapc(m_ins) != 32'(CNT_MOD - 1); i++)
      run_instr(rand_word(), 1'($urandom));
    run_instr(rand_word(), 1'b0);
    @(posedge clk);
    #1;
    chk("ins_wrap", 32'(bus.instr_count), 32'd0);
    chk("ins_wrap_model", 32'(bus.instr_count), wrapc(m_ins));

`ifdef CPU_SEQ_SINGLE_STEP_EN
    // Single-step: completion parks in PAUSE; one step gives one instruction
    run_instr(rand_word(), 1'b0);
    bus.step_mode = 1'b1;
    run_instr(16'h8003, 1'b0);
    for (int p = 0; p < 2; p++) begin
      repeat (3) begin
        @(negedge clk);
        chk_strobes("pause_strobes", 3'b000);
        chk("pause_busy", 32'(bus.busy), 32'd0);
        chk_counters("pause");
      end
      bus.step = 1'b1;
      run_instr(rand_word(), 1'b0);
    end
    @(negedge clk);
    chk_strobes("pause_last", 3'b000);
    bus.step_mode = 1'b0;
    run_instr(rand_word(), 1'b1);
`endif

    // Reset during EXEC2: strobes drop before the next edge
    @(negedge clk);
    chk_strobes("mid_fetch", 3'b100);
    bus.mem_q = 16'h1234;
    @(negedge clk);
    chk_strobes("mid_exec1", 3'b010);
    bus.EXTRA = 1'b1;
    @(negedge clk);
    chk_strobes("mid_exec2", 3'b001);
    #2 reset = 1'b1;
    #1;
    chk_strobes("async_rst", 3'b000);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_cyc = 0;
    m_ins = 0;
    @(negedge clk);
    chk_strobes("post_rst", 3'b000);
    chk("post_rst_ir", 32'(bus.IR), 32'd0);
    chk("post_rst_n", 32'(bus.N), 32'd0);
    chk_counters("post_rst");

    // STP halts and stays halted despite start
    bus.start = 1'b1;
    run_instr(16'h4321, 1'b1);
    run_instr(16'h7000, 1'b1);
    repeat (10) begin
      bus.start = 1'b1;
      bus.EXTRA = 1'($urandom);
      bus.mem_q = 16'($urandom);
      @(negedge clk);
      chk_strobes("halt_strobes", 3'b000);
      chk("halt_halted", 32'(bus.HALTED), 32'd1);
      chk_counters("halt");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
